// File: rtl/stack_param.sv
// Parameterised LIFO stack stored in a circular array, with push, pop and indexed peek.
// Results come back through a shared bidirectional data bus with one cycle of latency.
module stack_param #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 5,
    parameter int OVERWRITE = 0,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       COMMAND,
    input  logic [IDX_W-1:0] INDEX,
    inout  wire  [WIDTH-1:0] IO_DATA,
    output logic             DATA_VALID,
    output logic             ERROR,
    output logic [CNT_W-1:0] COUNT,
    output logic             FULL,
    output logic             EMPTY
);

    localparam logic [1:0]       CMD_PUSH  = 2'b01;
    localparam logic [1:0]       CMD_POP   = 2'b10;
    localparam logic [1:0]       CMD_PEEK  = 2'b11;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   LAST_WIDE = (IDX_W + 1)'(DEPTH - 1);
    localparam logic [IDX_W:0]   DEPTH_W   = (IDX_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0] top_reg, top_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             data_valid_reg, data_valid_next;
    logic             error_reg, error_next;
    logic             wr_en;

    logic [IDX_W-1:0] top_inc, top_dec, peek_addr;
    logic [IDX_W:0]   top_wide, idx_wide, peek_wide;
    logic [CNT_W-1:0] index_ext;
    logic             full_int, empty_int, index_ok;

    assign full_int  = (count_reg == DEPTH_C);
    assign empty_int = (count_reg == '0);
    assign index_ext = CNT_W'(INDEX);
    assign index_ok  = (index_ext < count_reg);

    // Explicit wrap instead of a power-of-two mask so any DEPTH stays in range.
    assign top_inc = (top_reg == LAST_IDX) ? '0 : top_reg + IDX_W'(1);
    assign top_dec = (top_reg == '0) ? LAST_IDX : top_reg - IDX_W'(1);

    assign top_wide = {1'b0, top_reg};
    assign idx_wide = {1'b0, INDEX};

    always_comb begin
        peek_wide = '0;
        if (top_wide >= idx_wide) begin
            peek_wide = top_wide - idx_wide;
        end else begin
            peek_wide = top_wide + DEPTH_W - idx_wide;
        end
    end

    // An INDEX beyond DEPTH is rejected anyway; clamp so the read never leaves the array.
    assign peek_addr = (peek_wide <= LAST_WIDE) ? peek_wide[IDX_W-1:0] : '0;

    always_comb begin
        top_next        = top_reg;
        count_next      = count_reg;
        out_next        = out_reg;
        data_valid_next = 1'b0;
        error_next      = 1'b0;
        wr_en           = 1'b0;
        case (COMMAND)
            CMD_PUSH: begin
                if (!full_int) begin
                    top_next   = top_inc;
                    count_next = count_reg + CNT_W'(1);
                    wr_en      = 1'b1;
                end else if (OVERWRITE != 0) begin
                    // The slot after the top of a full ring holds the oldest entry.
                    top_next = top_inc;
                    wr_en    = 1'b1;
                end else begin
                    error_next = 1'b1;
                end
            end
            CMD_POP: begin
                if (!empty_int) begin
                    out_next        = mem[top_reg];
                    top_next        = top_dec;
                    count_next      = count_reg - CNT_W'(1);
                    data_valid_next = 1'b1;
                end else begin
                    error_next = 1'b1;
                end
            end
            CMD_PEEK: begin
                if (index_ok) begin
                    out_next        = mem[peek_addr];
                    data_valid_next = 1'b1;
                end else begin
                    error_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            top_reg        <= LAST_IDX;
            count_reg      <= '0;
            out_reg        <= '0;
            data_valid_reg <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            top_reg        <= top_next;
            count_reg      <= count_next;
            out_reg        <= out_next;
            data_valid_reg <= data_valid_next;
            error_reg      <= error_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    mem[gi] <= '0;
                end else if (wr_en && (top_next == IDX_W'(gi))) begin
                    mem[gi] <= IO_DATA;
                end
            end
        end
    endgenerate

    assign IO_DATA    = COMMAND[1] ? out_reg : {WIDTH{1'bz}};
    assign DATA_VALID = data_valid_reg;
    assign ERROR      = error_reg;
    assign COUNT      = count_reg;
    assign FULL       = full_int;
    assign EMPTY      = empty_int;

endmodule

// File: tb/tb_stack_param.sv
// Scoreboard bench for stack_param: a reject-on-full and an overwrite-on-full instance
// share one stimulus stream and are checked against a queue-based stack model.
module tb_stack_param;

    localparam int W = 4;
    localparam int D = 5;

    typedef struct packed {
        logic [W-1:0] data;
        logic         dv;
        logic         err;
        logic [2:0]   cnt;
        logic         full;
        logic         empty;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] cmd;
    logic [2:0] idx;
    logic [W-1:0] drv;

    wire [W-1:0] io0, io1;
    logic        dv0, err0, full0, empty0, dv1, err1, full1, empty1;
    logic [2:0]  cnt0, cnt1;

    assign io0 = cmd[1] ? {W{1'bz}} : drv;
    assign io1 = cmd[1] ? {W{1'bz}} : drv;

    stack_param #(.WIDTH(W), .DEPTH(D), .OVERWRITE(0)) dut_rej (
        .CLK(clk), .RESET(rst), .COMMAND(cmd), .INDEX(idx), .IO_DATA(io0),
        .DATA_VALID(dv0), .ERROR(err0), .COUNT(cnt0), .FULL(full0), .EMPTY(empty0)
    );

    stack_param #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1)) dut_ovw (
        .CLK(clk), .RESET(rst), .COMMAND(cmd), .INDEX(idx), .IO_DATA(io1),
        .DATA_VALID(dv1), .ERROR(err1), .COUNT(cnt1), .FULL(full1), .EMPTY(empty1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    int   stk[2][$];
    int   outv[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
        end
    endtask

    // Reference behaviour: a plain queue per instance, top at the back.
    task automatic model_step(input logic [1:0] c, input logic [W-1:0] d, input int ix, input bit r);
        for (int u = 0; u < 2; u++) begin
            exp_t e;
            e = '0;
            if (r) begin
                stk[u].delete();
                outv[u] = 0;
            end else begin
                case (c)
                    2'b01: begin
                        if (stk[u].size() < D) begin
                            stk[u].push_back(int'(d));
                        end else if (u == 1) begin
                            void'(stk[u].pop_front());
                            stk[u].push_back(int'(d));
                        end else begin
                            e.err = 1'b1;
                        end
                    end
                    2'b10: begin
                        if (stk[u].size() > 0) begin
                            outv[u] = stk[u].pop_back();
                            e.dv = 1'b1;
                        end else begin
                            e.err = 1'b1;
                        end
                    end
                    2'b11: begin
                        if (ix < stk[u].size()) begin
                            outv[u] = stk[u][stk[u].size() - 1 - ix];
                            e.dv = 1'b1;
                        end else begin
                            e.err = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            e.data  = W'(outv[u]);
            e.cnt   = 3'(stk[u].size());
            e.full  = (stk[u].size() == D);
            e.empty = (stk[u].size() == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [W-1:0] d, input int ix, input bit r);
        exp_t e;
        rst = r;
        cmd = c;
        drv = d;
        idx = 3'(ix);
        model_step(c, d, ix, r);
        @(posedge clk);
        #1;
        $display("txn rst=%0d cmd=%b data=%0d idx=%0d | rej: cnt=%0d dv=%0d err=%0d io=%0h | ovw: cnt=%0d dv=%0d err=%0d io=%0h",
                 r, c, d, ix, cnt0, dv0, err0, io0, cnt1, dv1, err1, io1);
        for (int u = 0; u < 2; u++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("d%0d_scoreboard_empty", u), 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("d%0d_cnt", u),   32'(u == 0 ? cnt0 : cnt1),     32'(e.cnt));
                check($sformatf("d%0d_dv", u),    32'(u == 0 ? dv0 : dv1),       32'(e.dv));
                check($sformatf("d%0d_err", u),   32'(u == 0 ? err0 : err1),     32'(e.err));
                check($sformatf("d%0d_full", u),  32'(u == 0 ? full0 : full1),   32'(e.full));
                check($sformatf("d%0d_empty", u), 32'(u == 0 ? empty0 : empty1), 32'(e.empty));
                if (c[1]) begin
                    check($sformatf("d%0d_io", u), 32'(u == 0 ? io0 : io1), 32'(e.data));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd = 2'b00;
        drv = '0;
        idx = '0;
        outv[0] = 0;
        outv[1] = 0;

        // Reset state, then pop on empty.
        do_cmd(2'b00, 4'd0, 0, 1'b1);
        do_cmd(2'b10, 4'd0, 0, 1'b0);

        // Push 3, 7, 9 then pop.
        do_cmd(2'b01, 4'd3, 0, 1'b0);
        do_cmd(2'b01, 4'd7, 0, 1'b0);
        do_cmd(2'b01, 4'd9, 0, 1'b0);
        do_cmd(2'b10, 4'd0, 0, 1'b0);
        do_cmd(2'b00, 4'd0, 0, 1'b0);

        // Peek within and beyond the occupied depth.
        do_cmd(2'b00, 4'd0, 0, 1'b1);
        for (int k = 1; k <= 3; k++) do_cmd(2'b01, 4'(k), 0, 1'b0);
        do_cmd(2'b11, 4'd0, 0, 1'b0);
        do_cmd(2'b11, 4'd0, 2, 1'b0);
        do_cmd(2'b11, 4'd0, 3, 1'b0);
        do_cmd(2'b11, 4'd0, 7, 1'b0);

        // Reset overrides a coincident pop; the next pop finds the stack empty.
        do_cmd(2'b10, 4'd0, 0, 1'b1);
        do_cmd(2'b10, 4'd0, 0, 1'b0);

        // Fill past capacity: reject vs overwrite, then drain.
        for (int k = 1; k <= 6; k++) do_cmd(2'b01, 4'(k), 0, 1'b0);
        do_cmd(2'b11, 4'd0, 4, 1'b0);
        for (int k = 0; k < 5; k++) do_cmd(2'b10, 4'd0, 0, 1'b0);
        do_cmd(2'b10, 4'd0, 0, 1'b0);
        do_cmd(2'b01, 4'd0, 0, 1'b1);

        // Random traffic, biased towards pushes so the full boundary is reached.
        for (int k = 0; k < 60; k++) begin
            logic [1:0] c;
            int sel;
            sel = int'($urandom_range(0, 9));
            c = (sel < 4) ? 2'b01 : (sel < 6) ? 2'b10 : (sel < 9) ? 2'b11 : 2'b00;
            do_cmd(c, 4'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1'b0);
        end

        cmd = 2'b00;
        rst = 1'b0;
        if (exp_q.size() != 0) begin
            check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
